// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift-chain sequencer.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One bit cell of the sequencer's transmit and capture registers:
// a D flip-flop with load enable and asynchronous active-low clear.
module shift_stage (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Drives a serial shift chain for WIDTH cycles per accepted word while
// capturing the returning bits, then offers the captured word as a response.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             abort,
    output logic             ser_out,
    output logic             shift_en,
    input  logic             ser_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] tx_d;
    logic [WIDTH-1:0] rx_d;
    logic             accept;
    logic             shifting;
    logic             last;
    logic             reg_en;

    assign accept   = (state == IDLE) && req_valid;
    assign shifting = (state == SHIFT);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign reg_en   = accept | shifting;

    // Accept loads the word and clears capture; otherwise both registers shift.
    always_comb begin
        tx_d = req_data;
        rx_d = '0;
        if (!accept) begin
            if (MSB_FIRST)
                tx_d = {tx_reg[WIDTH-2:0], 1'b0};
            else
                tx_d = {1'b0, tx_reg[WIDTH-1:1]};
            rx_d = {rx_reg[WIDTH-2:0], ser_in};
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bits
        shift_stage u_tx (
            .clk (clk),
            .clr (clr),
            .en  (reg_en),
            .d   (tx_d[g]),
            .q   (tx_reg[g])
        );
        shift_stage u_rx (
            .clk (clk),
            .clr (clr),
            .en  (reg_en),
            .d   (rx_d[g]),
            .q   (rx_reg[g])
        );
    end

    // Abort takes priority over the final shift edge, so no response follows it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CW'(1);
                    if (abort)
                        state <= IDLE;
                    else if (last)
                        state <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign shift_en  = shifting;
    assign ser_out   = shifting & (MSB_FIRST ? tx_reg[WIDTH-1] : tx_reg[0]);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rx_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench: an MSB-first unit in loopback and an LSB-first unit
// feeding a 4-stage flip-flop chain whose tail returns to ser_in.
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b0;

    logic         req_valid_a = 1'b0;
    logic [W-1:0] req_data_a  = '0;
    logic         abort_a     = 1'b0;
    logic         rsp_ready_a = 1'b1;
    logic         req_ready_a, ser_out_a, shift_en_a, ser_in_a, rsp_valid_a, busy_a;
    logic [W-1:0] rsp_data_a;

    logic         req_valid_b = 1'b0;
    logic [W-1:0] req_data_b  = '0;
    logic         abort_b     = 1'b0;
    logic         rsp_ready_b = 1'b1;
    logic         req_ready_b, ser_out_b, shift_en_b, ser_in_b, rsp_valid_b, busy_b;
    logic [W-1:0] rsp_data_b;
    logic [W-1:0] chain;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] chain_m;

    always #5 clk = ~clk;

    assign ser_in_a = ser_out_a;
    assign ser_in_b = chain[W-1];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            chain <= '0;
        else if (shift_en_b)
            chain <= {chain[W-2:0], ser_out_b};
    end

    shift_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .clr(clr), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_data(req_data_a), .abort(abort_a), .ser_out(ser_out_a),
        .shift_en(shift_en_a), .ser_in(ser_in_a), .rsp_valid(rsp_valid_a),
        .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a), .busy(busy_a)
    );

    shift_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .clr(clr), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_data(req_data_b), .abort(abort_b), .ser_out(ser_out_b),
        .shift_en(shift_en_b), .ser_in(ser_in_b), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .busy(busy_b)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Responses are compared against the scoreboard on the handshake cycle.
    always @(negedge clk) begin
        if (rsp_valid_a && rsp_ready_a) begin
            if (exp_a.size() == 0)
                check_output("unexpected_rsp_a", {28'd0, rsp_data_a}, 32'hdead);
            else
                check_output("rsp_data_a", {28'd0, rsp_data_a}, {28'd0, exp_a.pop_front()});
        end
        if (rsp_valid_b && rsp_ready_b) begin
            if (exp_b.size() == 0)
                check_output("unexpected_rsp_b", {28'd0, rsp_data_b}, 32'hdead);
            else
                check_output("rsp_data_b", {28'd0, rsp_data_b}, {28'd0, exp_b.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (!req_ready_a && n < 40) begin
            step();
            n++;
        end
        if (!req_ready_a) check_output("timeout_idle_a", 32'd0, 32'd1);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while (!req_ready_b && n < 40) begin
            step();
            n++;
        end
        if (!req_ready_b) check_output("timeout_idle_b", 32'd0, 32'd1);
    endtask

    // Returns in the first shift cycle (T0+1).
    task automatic apply_stimulus_a(input logic [W-1:0] data);
        wait_idle_a();
        req_valid_a = 1'b1;
        req_data_a  = data;
        step();
        req_valid_a = 1'b0;
    endtask

    task automatic apply_stimulus_b(input logic [W-1:0] data);
        logic [W-1:0] rx;
        wait_idle_b();
        rx = '0;
        for (int i = 0; i < W; i++) begin
            rx      = {rx[W-2:0], chain_m[W-1]};
            chain_m = {chain_m[W-2:0], data[i]};
        end
        exp_b.push_back(rx);
        req_valid_b = 1'b1;
        req_data_b  = data;
        step();
        req_valid_b = 1'b0;
        for (int i = 0; i < W; i++) begin
            check_output("shift_en_b", {31'd0, shift_en_b}, 32'd1);
            check_output("ser_out_b", {31'd0, ser_out_b}, {31'd0, data[i]});
            step();
        end
        check_output("rsp_valid_b", {31'd0, rsp_valid_b}, 32'd1);
        step();
    endtask

    task automatic abort_run(input int abort_cycle, input string tag);
        int pulses = 0;
        int seen_rsp = 0;
        apply_stimulus_a(4'b1111);
        for (int c = 1; c <= 7; c++) begin
            if (c == abort_cycle) abort_a = 1'b1;
            if (shift_en_a) pulses++;
            if (rsp_valid_a) seen_rsp++;
            step();
            abort_a = 1'b0;
        end
        check_output({tag, "_pulses"}, pulses, abort_cycle);
        check_output({tag, "_no_rsp"}, seen_rsp, 0);
        check_output({tag, "_idle"}, {31'd0, req_ready_a}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] tv;
        chain_m = '0;
        #3;
        check_output("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
        check_output("rst_shift_en", {31'd0, shift_en_a}, 32'd0);
        check_output("rst_ser_out", {31'd0, ser_out_a}, 32'd0);
        check_output("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
        check_output("rst_rsp_data", {28'd0, rsp_data_a}, 32'd0);
        check_output("rst_busy", {31'd0, busy_a}, 32'd0);
        #20 clr = 1'b1;
        step();

        tv = 4'b1011;
        exp_a.push_back(tv);
        apply_stimulus_a(tv);
        for (int i = W - 1; i >= 0; i--) begin
            check_output("loop_shift_en", {31'd0, shift_en_a}, 32'd1);
            check_output("loop_ser_out", {31'd0, ser_out_a}, {31'd0, tv[i]});
            check_output("loop_busy", {31'd0, busy_a}, 32'd1);
            step();
        end
        check_output("loop_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
        check_output("loop_shift_done", {31'd0, shift_en_a}, 32'd0);
        step();

        rsp_ready_a = 1'b0;
        exp_a.push_back(4'b0101);
        apply_stimulus_a(4'b0101);
        req_valid_a = 1'b1;
        req_data_a  = 4'b1100;
        for (int i = 0; i < W; i++) step();
        for (int i = 0; i < 10; i++) begin
            check_output("bp_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
            check_output("bp_rsp_data", {28'd0, rsp_data_a}, 32'h5);
            check_output("bp_req_ready", {31'd0, req_ready_a}, 32'd0);
            check_output("bp_shift_en", {31'd0, shift_en_a}, 32'd0);
            step();
        end
        rsp_ready_a = 1'b1;
        step();
        check_output("bp_idle_after_hs", {31'd0, req_ready_a}, 32'd1);
        exp_a.push_back(4'b1100);
        step();
        req_valid_a = 1'b0;
        check_output("bp_resume_shift", {31'd0, shift_en_a}, 32'd1);
        wait_idle_a();

        abort_run(2, "abort_mid");
        abort_run(4, "abort_last");
        exp_a.push_back(4'b0110);
        apply_stimulus_a(4'b0110);
        for (int i = 0; i < W + 1; i++) step();
        wait_idle_a();

        apply_stimulus_a(4'b1010);
        step();
        #2 clr = 1'b0;
        #1;
        check_output("clr_shift_en", {31'd0, shift_en_a}, 32'd0);
        check_output("clr_ser_out", {31'd0, ser_out_a}, 32'd0);
        check_output("clr_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
        check_output("clr_req_ready", {31'd0, req_ready_a}, 32'd1);
        check_output("clr_busy", {31'd0, busy_a}, 32'd0);
        #4 clr = 1'b1;
        chain_m = '0;
        for (int i = 0; i < 8; i++) step();
        check_output("clr_no_rsp", {31'd0, rsp_valid_a}, 32'd0);

        apply_stimulus_b(4'b0001);
        apply_stimulus_b(4'b0110);
        step();

        check_output("sb_empty_a", exp_a.size(), 0);
        check_output("sb_empty_b", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the team's D-flip-flop serial shift-register chain. It accepts a parallel word over a valid/ready handshake and drives the chain's serial input and shift enable for exactly WIDTH cycles. While doing so it mirrors the chain into an internal capture register, then presents the captured word over a second valid/ready handshake. It sits between a parallel command source and any serial shift path (loopback, external serial device, or a bank of chained dff stages).

## Interface
- WIDTH, 4, word length and shift count per transaction (2..32)
- MSB_FIRST, 1, 1: ser_out drives req_data MSB first; 0: LSB first

- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- req_valid  in  1  command word available
- req_ready  out  1  controller can accept a command
- req_data  in  WIDTH  word to shift out
- abort  in  1  synchronous cancel of a transaction in progress
- ser_out  out  1  serial bit to chain input (din)
- shift_en  out  1  chain advances one position this cycle
- ser_in  in  1  serial bit returning from the chain tail (or external device)
- rsp_valid  out  1  captured word available
- rsp_ready  in  1  consumer takes captured word
- rsp_data  out  WIDTH  captured word
- busy  out  1  high in SHIFT or RESP

## Operation
- States: IDLE, SHIFT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready: tx_reg<=req_data, cnt<=0, rx_reg<=0, go to SHIFT.
- SHIFT: shift_en=1 every cycle. ser_out = tx_reg[WIDTH-1] if MSB_FIRST, else tx_reg[0]. On each edge:
  - tx_reg shifts toward the emitted end.
  - rx_reg<={rx_reg[WIDTH-2:0], ser_in}, so the first bit received ends in the MSB.
  - cnt increments.
  - The edge with cnt==WIDTH-1 moves to RESP.
- RESP: rsp_valid=1, rsp_data=rx_reg, held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE.
- abort in SHIFT: return to IDLE at the next edge. No response is issued, and shift_en is deasserted from that edge on. abort is ignored in IDLE and RESP.
- abort and cnt==WIDTH-1 on the same edge: abort wins. No response is issued.
- req_ready=0 outside IDLE. Commands are never queued.
- ser_out=0 whenever shift_en=0.
- cnt width: $clog2(WIDTH); counting is exact with no wrap, because cnt is reset on every accept.

## Timing
- Reset (clr low, asynchronous) forces the following until the first clk edge after release:
  - state=IDLE
  - req_ready=1
  - shift_en=0, ser_out=0
  - rsp_valid=0, rsp_data=0
  - busy=0
- Accept edge T0. shift_en is high in cycles T0+1 .. T0+WIDTH, exactly WIDTH cycles.
- rsp_valid rises in cycle T0+WIDTH+1. Minimum command-to-command period is WIDTH+2 cycles when rsp_ready is held high.
- ser_in is sampled on the same edge that advances the chain. A zero-latency loopback (ser_out→ser_in) returns req_data unchanged when MSB_FIRST=1.
- clr asserted mid-SHIFT or mid-RESP: the transaction is dropped and all outputs take their reset values immediately.

## Structure
- Shared package shift_pkg:
  - state enum (IDLE, SHIFT, RESP)
  - default WIDTH constant
- Sub-module shift_stage: a single D flip-flop with enable and the same clr, used as the bit cell of both tx_reg and rx_reg. It is instantiated WIDTH times per register via generate.
- The FSM and counter stay in shift_seq_ctrl.

## Test plan
- Reset: clr low mid-SHIFT of 4'b1010 → shift_en=0, rsp_valid=0, req_ready=1 asynchronously; no rsp after release.
- Loopback: WIDTH=4, MSB_FIRST=1, ser_out→ser_in, send 4'b1011 → ser_out sequence 1,0,1,1 over 4 shift_en cycles; rsp_data=4'b1011 at T0+5.
- Back-pressure: rsp_ready low 10 cycles after response → rsp_valid and rsp_data stable, req_ready=0, shift_en=0 throughout; accept resumes the cycle after handshake.
- Abort: abort asserted at the second shift cycle of 4'b1111 → IDLE next edge, exactly 2 shift_en pulses seen, no rsp_valid.
- Abort on final shift edge: abort coincident with cnt==3 → no rsp_valid; next command 4'b0110 completes normally with rsp_data=4'b0110.
- LSB_FIRST (MSB_FIRST=0): send 4'b0001, ser_in driven by a 4-stage dff chain tail → ser_out 1,0,0,0; rsp_data equals the chain-delayed stream, checked against the reference model.
